// File: rtl/test_monitor.sv
// CPU self-test monitor: waits out an idle delay, then watches stores,
// folds them into a checksum, captures the signature and grades the run.
module test_monitor #(
  parameter int unsigned          PC_WIDTH    = 8,
  parameter int unsigned          ADDR_WIDTH  = 8,
  parameter int unsigned          DATA_W      = 32,
  parameter int unsigned          START_DELAY = 10,
  parameter logic [PC_WIDTH-1:0]  END_PC      = 8'h80,
  parameter logic [ADDR_WIDTH-1:0] SIG_ADDR   = 8'hF0,
  parameter logic [DATA_W-1:0]    EXPECTED    = 32'h0000_0000,
  parameter int unsigned          TIMEOUT     = 5000,
  parameter int unsigned          STALL_LIMIT = 64
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [PC_WIDTH-1:0]   pc,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [1:0]            mode,
  input  logic [DATA_W-1:0]     d_out,
  output logic [1:0]            state,
  output logic [31:0]           cycle_cnt,
  output logic [15:0]           store_cnt,
  output logic [DATA_W-1:0]     checksum,
  output logic                  done,
  output logic                  pass,
  output logic [1:0]            fail_code
);

  localparam int unsigned SW = $clog2(STALL_LIMIT + 1);
  localparam logic [SW-1:0] STALL_LAST = SW'(STALL_LIMIT - 1);
  localparam logic [31:0]   TO_LAST    = 32'(TIMEOUT - 1);
  localparam logic [31:0]   DLY_N      = 32'(START_DELAY);

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_PASS = 2'b10,
    S_FAIL = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [31:0]         dly_q, dly_d;
  logic [31:0]         cyc_q, cyc_d;
  logic [15:0]         stc_q, stc_d;
  logic [DATA_W-1:0]   cks_q, cks_d;
  logic [DATA_W-1:0]   sig_q, sig_d;
  logic                seen_q, seen_d;
  logic [SW-1:0]       stall_q, stall_d;
  logic [PC_WIDTH-1:0] pc_prev_q, pc_prev_d;
  logic                done_q, done_d;
  logic                pass_q, pass_d;
  logic [1:0]          fcode_q, fcode_d;

  logic [DATA_W-1:0]   wmask;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W-1:0]   cks_rot;

  always_comb begin
    wmask = '1;
    unique case (1'b1)
      mode == 2'b00: wmask = DATA_W'(8'hFF);
      mode == 2'b01: wmask = DATA_W'(16'hFFFF);
      mode[1]:       wmask = '1;
    endcase
  end

  assign wdata   = d_out & wmask;
  assign cks_rot = {cks_q[DATA_W-2:0], cks_q[DATA_W-1]};

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    cyc_d     = cyc_q;
    stc_d     = stc_q;
    cks_d     = cks_q;
    sig_d     = sig_q;
    seen_d    = seen_q;
    stall_d   = stall_q;
    pc_prev_d = pc;
    done_d    = done_q;
    pass_d    = pass_q;
    fcode_d   = fcode_q;
    unique case (state_q)
      S_IDLE: begin
        if (dly_q + 32'd1 >= DLY_N) state_d = S_RUN;
        else dly_d = dly_q + 32'd1;
      end
      S_RUN: begin
        cyc_d   = (&cyc_q) ? cyc_q : cyc_q + 32'd1;
        stall_d = (pc != pc_prev_q) ? '0 : stall_q + SW'(1);
        if (wr_en) begin
          stc_d = (&stc_q) ? stc_q : stc_q + 16'd1;
          cks_d = cks_rot ^ wdata;
          if (wr_addr == SIG_ADDR) begin
            sig_d  = wdata;
            seen_d = 1'b1;
          end
        end
        // end-of-test beats timeout, timeout beats stall
        if (pc == END_PC) begin
          done_d = 1'b1;
          if (seen_d && sig_d == EXPECTED) begin
            state_d = S_PASS;
            pass_d  = 1'b1;
          end else begin
            state_d = S_FAIL;
            fcode_d = 2'd2;
          end
        end else if (cyc_q == TO_LAST) begin
          state_d = S_FAIL;
          done_d  = 1'b1;
          fcode_d = 2'd1;
        end else if (stall_q == STALL_LAST) begin
          state_d = S_FAIL;
          done_d  = 1'b1;
          fcode_d = 2'd3;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      dly_q     <= '0;
      cyc_q     <= '0;
      stc_q     <= '0;
      cks_q     <= '0;
      sig_q     <= '0;
      seen_q    <= 1'b0;
      stall_q   <= '0;
      pc_prev_q <= '0;
      done_q    <= 1'b0;
      pass_q    <= 1'b0;
      fcode_q   <= '0;
    end else begin
      state_q   <= state_d;
      dly_q     <= dly_d;
      cyc_q     <= cyc_d;
      stc_q     <= stc_d;
      cks_q     <= cks_d;
      sig_q     <= sig_d;
      seen_q    <= seen_d;
      stall_q   <= stall_d;
      pc_prev_q <= pc_prev_d;
      done_q    <= done_d;
      pass_q    <= pass_d;
      fcode_q   <= fcode_d;
    end
  end

  assign state     = state_q;
  assign cycle_cnt = cyc_q;
  assign store_cnt = stc_q;
  assign checksum  = cks_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign fail_code = fcode_q;

endmodule

// File: tb/tb_test_monitor.sv
// Bench for test_monitor: three parameterisations share one stimulus
// stream and are graded against a behavioural model every cycle.
module tb_test_monitor;

  logic        clk;
  logic        rst_n;
  logic [7:0]  pc;
  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [1:0]  mode;
  logic [31:0] d_out;

  logic [1:0]  st_o [3];
  logic [31:0] cc_o [3];
  logic [15:0] sc_o [3];
  logic [31:0] ck_o [3];
  logic        dn_o [3];
  logic        ps_o [3];
  logic [1:0]  fc_o [3];

  int tests = 0;
  int fails = 0;

  test_monitor #(.EXPECTED(32'h1234_5678)) u0 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .wr_en(wr_en),
    .wr_addr(wr_addr), .mode(mode), .d_out(d_out),
    .state(st_o[0]), .cycle_cnt(cc_o[0]), .store_cnt(sc_o[0]),
    .checksum(ck_o[0]), .done(dn_o[0]), .pass(ps_o[0]),
    .fail_code(fc_o[0]));

  test_monitor #(.TIMEOUT(20)) u1 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .wr_en(wr_en),
    .wr_addr(wr_addr), .mode(mode), .d_out(d_out),
    .state(st_o[1]), .cycle_cnt(cc_o[1]), .store_cnt(sc_o[1]),
    .checksum(ck_o[1]), .done(dn_o[1]), .pass(ps_o[1]),
    .fail_code(fc_o[1]));

  test_monitor #(.TIMEOUT(64)) u2 (
    .clk(clk), .rst_n(rst_n), .pc(pc), .wr_en(wr_en),
    .wr_addr(wr_addr), .mode(mode), .d_out(d_out),
    .state(st_o[2]), .cycle_cnt(cc_o[2]), .store_cnt(sc_o[2]),
    .checksum(ck_o[2]), .done(dn_o[2]), .pass(ps_o[2]),
    .fail_code(fc_o[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // reference model: one record per instance
  int unsigned P_TO  [3] = '{5000, 20, 64};
  logic [31:0] P_EXP [3] = '{32'h1234_5678, 32'h0, 32'h0};

  int unsigned m_st   [3];
  int unsigned m_idle [3];
  int unsigned m_stall[3];
  int unsigned m_fc   [3];
  int unsigned m_stc  [3];
  logic [31:0] m_cyc  [3];
  logic [31:0] m_cks  [3];
  logic [31:0] m_sig  [3];
  bit          m_seen [3];
  logic [7:0]  m_prev;

  task automatic model_step();
    logic [31:0] data;
    logic [31:0] oc;
    int unsigned os;
    if (mode == 2'd0)      data = d_out & 32'h0000_00FF;
    else if (mode == 2'd1) data = d_out & 32'h0000_FFFF;
    else                   data = d_out;
    for (int i = 0; i < 3; i++) begin
      if (!rst_n) begin
        m_st[i] = 0; m_idle[i] = 0; m_stall[i] = 0; m_fc[i] = 0;
        m_stc[i] = 0; m_cyc[i] = 0; m_cks[i] = 0; m_sig[i] = 0;
        m_seen[i] = 0;
      end else if (m_st[i] == 0) begin
        m_idle[i]++;
        if (m_idle[i] == 10) m_st[i] = 1;
      end else if (m_st[i] == 1) begin
        oc = m_cyc[i];
        os = m_stall[i];
        if (m_cyc[i] != 32'hFFFF_FFFF) m_cyc[i] = m_cyc[i] + 1;
        m_stall[i] = (pc == m_prev) ? os + 1 : 0;
        if (wr_en) begin
          if (m_stc[i] < 65535) m_stc[i]++;
          m_cks[i] = {m_cks[i][30:0], m_cks[i][31]} ^ data;
          if (wr_addr == 8'hF0) begin
            m_sig[i]  = data;
            m_seen[i] = 1;
          end
        end
        if (pc == 8'h80) begin
          if (m_seen[i] && m_sig[i] == P_EXP[i]) m_st[i] = 2;
          else begin m_st[i] = 3; m_fc[i] = 2; end
        end else if (oc == 32'(P_TO[i] - 1)) begin
          m_st[i] = 3; m_fc[i] = 1;
        end else if (os == 63) begin
          m_st[i] = 3; m_fc[i] = 3;
        end
      end
    end
    m_prev = pc;
  endtask

  task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("u%0d.state", i), 32'(st_o[i]), 32'(m_st[i]));
      chk($sformatf("u%0d.cycle_cnt", i), cc_o[i], m_cyc[i]);
      chk($sformatf("u%0d.store_cnt", i), 32'(sc_o[i]), 32'(m_stc[i]));
      chk($sformatf("u%0d.checksum", i), ck_o[i], m_cks[i]);
      chk($sformatf("u%0d.done", i), 32'(dn_o[i]), 32'(m_st[i] >= 2));
      chk($sformatf("u%0d.pass", i), 32'(ps_o[i]), 32'(m_st[i] == 2));
      chk($sformatf("u%0d.fail_code", i), 32'(fc_o[i]), 32'(m_fc[i]));
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check_all();
  endtask

  task automatic drive(logic [7:0] p, logic w, logic [7:0] a,
                       logic [1:0] m, logic [31:0] d);
    pc = p; wr_en = w; wr_addr = a; mode = m; d_out = d;
  endtask

  task automatic rnd_run_cycle(bit allow_sig);
    logic [7:0] a;
    a = 8'($urandom_range(0, 8'hEF));
    if (allow_sig && $urandom_range(0, 7) == 0) a = 8'hF0;
    drive(8'($urandom_range(0, 8'h7F)), 1'($urandom), a,
          2'($urandom), $urandom);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
  endtask

  task automatic idle_phase();
    for (int k = 0; k < 10; k++) begin
      drive(8'($urandom_range(0, 8'h7F)), 1'b1, 8'hF0, 2'd2,
            32'h1234_5678);
      tick();
    end
  endtask

  initial begin
    rst_n = 1'b0;
    drive(8'h00, 1'b0, 8'h00, 2'd0, 32'h0);
    tick();
    tick();
    chk("reset.state", 32'(st_o[0]), 32'd0);
    chk("reset.cycle_cnt", cc_o[0], 32'd0);
    chk("reset.done", 32'(dn_o[0]), 32'd0);

    // signature pass; idle stores ignored
    rst_n = 1'b1;
    idle_phase();
    chk("idle.store_cnt", 32'(sc_o[0]), 32'd0);
    chk("idle.to_run", 32'(st_o[0]), 32'd1);
    for (int k = 0; k < 5; k++) begin
      drive(8'($urandom_range(0, 8'h7F)), 1'b0, 8'h00, 2'd0, $urandom);
      tick();
    end
    drive(8'h20, 1'b1, 8'hF0, 2'd2, 32'h1234_5678);
    tick();
    drive(8'h80, 1'b0, 8'h00, 2'd0, 32'h0);
    tick();
    chk("sig.state", 32'(st_o[0]), 32'd2);
    chk("sig.pass", 32'(ps_o[0]), 32'd1);
    chk("sig.fail_code", 32'(fc_o[0]), 32'd0);
    chk("sig.store_cnt", 32'(sc_o[0]), 32'd1);
    chk("sig.mismatch_code", 32'(fc_o[1]), 32'd2);
    for (int k = 0; k < 6; k++) begin
      rnd_run_cycle(1'b1);
      tick();
    end
    chk("sticky.state", 32'(st_o[0]), 32'd2);
    chk("sticky.store_cnt", 32'(sc_o[0]), 32'd1);

    // checksum, then missing signature
    do_reset();
    idle_phase();
    drive(8'h04, 1'b1, 8'h10, 2'd0, 32'hFFFF_FFA5);
    tick();
    drive(8'h08, 1'b1, 8'h20, 2'd3, 32'h0000_0001);
    tick();
    chk("cks.value", ck_o[0], 32'h0000_014B);
    chk("cks.store_cnt", 32'(sc_o[0]), 32'd2);
    drive(8'h80, 1'b0, 8'h00, 2'd0, 32'h0);
    tick();
    chk("nosig.state", 32'(st_o[0]), 32'd3);
    chk("nosig.fail_code", 32'(fc_o[0]), 32'd2);

    // timeout with toggling pc
    do_reset();
    idle_phase();
    for (int k = 0; k < 30; k++) begin
      drive((k % 2 == 0) ? 8'h00 : 8'h04, 1'($urandom),
            8'($urandom_range(0, 8'hEF)), 2'($urandom), $urandom);
      tick();
    end
    chk("timeout.state", 32'(st_o[1]), 32'd3);
    chk("timeout.fail_code", 32'(fc_o[1]), 32'd1);
    chk("timeout.cycle_cnt", cc_o[1], 32'd20);
    chk("timeout.other_run", 32'(st_o[0]), 32'd1);

    // stall, and stall coinciding with timeout
    rst_n = 1'b0;
    drive(8'h10, 1'b0, 8'h00, 2'd0, 32'h0);
    tick();
    rst_n = 1'b1;
    for (int k = 0; k < 80; k++) begin
      drive(8'h10, 1'($urandom), 8'($urandom_range(0, 8'hEF)),
            2'($urandom), $urandom);
      tick();
    end
    chk("stall.fail_code", 32'(fc_o[0]), 32'd3);
    chk("stall.cycle_cnt", cc_o[0], 32'd64);
    chk("stall_to.fail_code", 32'(fc_o[2]), 32'd1);
    chk("stall_to.cycle_cnt", cc_o[2], 32'd64);

    // mid-run reset restarts the idle delay
    do_reset();
    idle_phase();
    for (int k = 0; k < 15; k++) begin
      rnd_run_cycle(1'b1);
      tick();
    end
    rst_n = 1'b0;
    tick();
    chk("midrst.state", 32'(st_o[0]), 32'd0);
    chk("midrst.cycle_cnt", cc_o[0], 32'd0);
    chk("midrst.store_cnt", 32'(sc_o[0]), 32'd0);
    chk("midrst.checksum", ck_o[0], 32'd0);
    chk("midrst.fail_code", 32'(fc_o[0]), 32'd0);
    rst_n = 1'b1;
    for (int k = 0; k < 9; k++) begin
      rnd_run_cycle(1'b1);
      tick();
    end
    chk("midrst.idle9", 32'(st_o[0]), 32'd0);
    rnd_run_cycle(1'b1);
    tick();
    chk("midrst.run10", 32'(st_o[0]), 32'd1);

    // random soak with occasional end-pc, holds and resets
    for (int s = 0; s < 4; s++) begin
      do_reset();
      for (int k = 0; k < 400; k++) begin
        rnd_run_cycle(1'b1);
        if ($urandom_range(0, 3) == 0) pc = m_prev;
        if ($urandom_range(0, 149) == 0) pc = 8'h80;
        if ($urandom_range(0, 3) == 0) d_out = 32'h1234_5678;
        rst_n = ($urandom_range(0, 199) != 0);
        tick();
      end
      rst_n = 1'b1;
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/test_monitor.md
TEST_MONITOR -- requirements
Module: test_monitor

Interface
REQ-001 Parameter PC_WIDTH, default 8: width of the monitored PC.
REQ-002 Parameter ADDR_WIDTH, default 8: width of the data-memory write address.
REQ-003 Parameter DATA_W, default 32: store data and checksum width.
REQ-004 Parameter START_DELAY, default 10: cycles spent in IDLE after reset release.
REQ-005 Parameter END_PC, default 8'h80: PC value that ends the test.
REQ-006 Parameter SIG_ADDR, default 8'hF0: write address of the signature word.
REQ-007 Parameter EXPECTED, default 32'h0000_0000: required signature value.
REQ-008 Parameter TIMEOUT, default 5000: maximum RUN cycles.
REQ-009 Parameter STALL_LIMIT, default 64: consecutive cycles with an unchanged PC that count as a hang.
REQ-010 Port clk, input, 1 bit: clock; all state updates on its rising edge.
REQ-011 Port rst_n, input, 1 bit: reset, synchronous, active-low.
REQ-012 Port pc, input, PC_WIDTH bits: CPU program counter.
REQ-013 Port wr_en, input, 1 bit: CPU data-memory write strobe.
REQ-014 Port wr_addr, input, ADDR_WIDTH bits: CPU data-memory write address.
REQ-015 Port mode, input, 2 bits: store size (00 byte, 01 half, 10 word, 11 word).
REQ-016 Port d_out, input, DATA_W bits: CPU store data.
REQ-017 Port state, output, 2 bits: 00 IDLE, 01 RUN, 10 PASS, 11 FAIL.
REQ-018 Port cycle_cnt, output, 32 bits: count of RUN cycles.
REQ-019 Port store_cnt, output, 16 bits: count of stores accepted in RUN.
REQ-020 Port checksum, output, DATA_W bits: running store checksum.
REQ-021 Port done, output, 1 bit: high in PASS or FAIL.
REQ-022 Port pass, output, 1 bit: high in PASS only.
REQ-023 Port fail_code, output, 2 bits: 0 none, 1 timeout, 2 mismatch or missing signature, 3 stall.

Function
REQ-024 IDLE SHALL count START_DELAY cycles and then enter RUN; stores and PC activity in IDLE SHALL be ignored.
REQ-025 In RUN, cycle_cnt SHALL increment by 1 every cycle and saturate at 32'hFFFF_FFFF.
REQ-026 In RUN, every cycle with wr_en=1 SHALL increment store_cnt, saturating at 16'hFFFF.
REQ-027 Store data SHALL be masked by mode: byte takes d_out[7:0], half takes d_out[15:0], word takes all bits, each zero-extended.
REQ-028 On each RUN store, checksum SHALL become (checksum rotated left by 1) XOR the masked data.
REQ-029 A RUN store with wr_addr==SIG_ADDR SHALL capture the masked data as the signature and set an internal sig_seen flag.
REQ-030 The stall counter SHALL reset to 0 when pc differs from its previous-cycle value and increment otherwise.
REQ-031 RUN with pc==END_PC SHALL go to PASS if sig_seen is set and the signature equals EXPECTED, otherwise to FAIL with fail_code=2.
REQ-032 RUN with cycle_cnt==TIMEOUT-1 and pc!=END_PC SHALL go to FAIL with fail_code=1.
REQ-033 RUN with the stall counter at STALL_LIMIT-1, and neither REQ-031 nor REQ-032 applying, SHALL go to FAIL with fail_code=3.
REQ-034 Precedence SHALL be END_PC over timeout over stall.
REQ-035 A store in the END_PC cycle SHALL be counted and included in the checksum and in the signature compare.
REQ-036 PASS and FAIL SHALL be sticky until reset.
REQ-037 In PASS and FAIL, all counters, the checksum and the signature SHALL be frozen.
REQ-038 done and pass SHALL be registered and SHALL assert in the first cycle the state reads PASS or FAIL.

Reset
REQ-039 rst_n=0 at a clock edge SHALL force state=IDLE.
REQ-040 That reset SHALL also clear cycle_cnt, store_cnt, checksum, signature, sig_seen, the stall counter, done, pass and fail_code to 0.
REQ-041 Reset SHALL take effect in any state, including mid-RUN, and the IDLE delay SHALL restart.

Verification
REQ-042 Signature pass: store word 32'h1234_5678 to 8'hF0 with EXPECTED=32'h1234_5678, then pc=8'h80 -> PASS, pass=1, fail_code=0, store_cnt=1.
REQ-043 Missing signature: pc reaches 8'h80 with no store to 8'hF0 -> FAIL, fail_code=2.
REQ-044 Timeout: TIMEOUT=20, pc toggles and never reaches END_PC -> FAIL, fail_code=1, cycle_cnt=20.
REQ-045 Stall: pc held at 8'h10 for 64 cycles -> FAIL, fail_code=3; repeat the hold with a timeout in the same cycle -> fail_code=1.
REQ-046 Checksum: byte store of d_out=32'hFFFF_FFA5, then word store of 32'h0000_0001 -> checksum=32'h0000_014B; store asserted during IDLE -> store_cnt unchanged.
REQ-047 Mid-run reset: rst_n=0 during RUN -> all outputs 0, state=IDLE, RUN re-entered START_DELAY cycles after release.
